// File: rtl/mio_uart_tx_if.sv
// mio_uart_tx_if: core data-bus view of the UART transmitter register window.
// The core drives address, store data and write enable; the UART returns sel and read data.
interface mio_uart_tx_if;
    logic        MemRW;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        sel;
    logic [31:0] rdata;

    modport master (output MemRW, Addr_out, Data_out, input  sel, rdata);
    modport slave  (input  MemRW, Addr_out, Data_out, output sel, rdata);
endinterface

// File: rtl/mio_uart_tx.sv
// mio_uart_tx: memory-mapped FIFO-buffered UART transmitter, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data (8E1).
module mio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DIV_RESET  = 868
) (
    input  logic         clk,
    input  logic         rst,
    mio_uart_tx_if.slave bus,
    output logic         tx,
    output logic         irq_empty
);
    // state    | meaning
    // S_IDLE   | line idle high, waiting for a byte in the FIFO
    // S_START  | start bit (low) for one bit period
    // S_DATA   | data bits, LSB first, bit_idx 0..7
    // S_PARITY | even parity bit (only with UART_TX_PARITY_EN)
    // S_STOP   | stop bit (high); chains straight into S_START if data waits
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_next;
    logic          overflow;
    logic [15:0]   div_reg, period, timer;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [2:0]    bit_idx;
    state_t        state, state_next;

    logic [1:0] offset;
    logic       wr_stb, push_req, push, pop, full, empty;
    logic       timer_zero, timer_reload, shift_en, tx_next;
    logic       unused_bits;

    assign offset      = bus.Addr_out[3:2];
    assign bus.sel     = (bus.Addr_out[31:4] == BASE_ADDR[31:4]);
    assign wr_stb      = bus.sel & bus.MemRW;
    assign full        = (level == LW'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign push_req    = wr_stb && (offset == 2'd0);
    // Full is judged before the edge, so a same-edge pop never rescues the byte.
    assign push        = push_req && !full;
    assign level_next  = level + LW'(push) - LW'(pop);
    assign timer_zero  = (timer == '0);
    assign unused_bits = ^{bus.Addr_out[1:0], bus.Data_out[31:16]};

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (offset)
                2'd1:    bus.rdata = {16'h0, 8'(level), 3'b000, PAR_EN, overflow,
                                      state != S_IDLE, empty, full};
                2'd2:    bus.rdata = {16'h0, div_reg};
                default: bus.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        timer_reload = 1'b0;
        shift_en     = 1'b0;
        tx_next      = tx;
        case (state)
            S_IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_START;
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (timer_zero) begin
                    timer_reload = 1'b1;
                    state_next   = S_DATA;
                    tx_next      = shreg[0];
                end
            end
            S_DATA: begin
                if (timer_zero) begin
                    timer_reload = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
                        tx_next    = parity_bit;
`else
                        state_next = S_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        shift_en = 1'b1;
                        tx_next  = shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (timer_zero) begin
                    timer_reload = 1'b1;
                    state_next   = S_STOP;
                    tx_next      = 1'b1;
                end
            end
            S_STOP: begin
                if (timer_zero) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = S_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.Data_out[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            div_reg    <= 16'(DIV_RESET);
            period     <= 16'(DIV_RESET);
            timer      <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            irq_empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;

            if (push_req && full)                overflow <= 1'b1;
            else if (wr_stb && offset == 2'd1)   overflow <= 1'b0;

            if (wr_stb && offset == 2'd2)
                div_reg <= (bus.Data_out[15:0] == 16'h0) ? 16'd1 : bus.Data_out[15:0];

            // The bit period is frozen per frame so DIV writes only affect later frames.
            if (pop) begin
                shreg      <= fifo_mem[rd_ptr];
                parity_bit <= ^fifo_mem[rd_ptr];
                period     <= div_reg;
                timer      <= div_reg - 16'd1;
                bit_idx    <= '0;
            end else if (timer_reload) begin
                timer <= period - 16'd1;
            end else if (!timer_zero) begin
                timer <= timer - 16'd1;
            end

            if (shift_en) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end

            tx        <= tx_next;
            irq_empty <= (state_next == S_IDLE) && (level_next == '0);
        end
    end
endmodule

// File: tb/tb_mio_uart_tx.sv
// tb_mio_uart_tx: scoreboard bench; a timing model predicts every frame and a
// line monitor decodes tx and compares against the predicted queue.
`timescale 1ns/1ps
module tb_mio_uart_tx;
    localparam logic [31:0] BASE    = 32'hF000_0000;
    localparam int          DEPTH   = 8;
    localparam int          DIV_RST = 868;
`ifdef UART_TX_PARITY_EN
    localparam int NB   = 11;
    localparam bit PBIT = 1'b1;
`else
    localparam int NB   = 10;
    localparam bit PBIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, irq_empty;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mio_uart_tx_if bus ();

    mio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One accepted byte: push edge, pop (start) edge, end edge, data, bit period.
    typedef struct {
        int         p;
        int         s;
        int         e;
        logic [7:0] d;
        int         dv;
    } frm_t;

    frm_t frames[$];
    frm_t exp_q[$];
    int   div_m    = DIV_RST;
    bit   ovf_m    = 1'b0;
    int   last_end = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        frames.delete();
        exp_q.delete();
        div_m    = DIV_RST;
        ovf_m    = 1'b0;
        last_end = 0;
    endfunction

    function automatic void push_model(input logic [7:0] d, input int p);
        int   lvl = 0;
        frm_t f;
        foreach (frames[i]) if (frames[i].p < p && frames[i].s >= p) lvl++;
        if (lvl >= DEPTH) begin
            ovf_m = 1'b1;
            return;
        end
        f.p  = p;
        f.s  = (p + 1 > last_end) ? p + 1 : last_end;
        f.dv = div_m;
        f.e  = f.s + NB * div_m;
        f.d  = d;
        last_end = f.e;
        frames.push_back(f);
        exp_q.push_back(f);
    endfunction

    function automatic logic [31:0] status_m(input int c);
        int lvl  = 0;
        bit busy = 1'b0;
        foreach (frames[i]) begin
            if (frames[i].p <= c && frames[i].s > c) lvl++;
            if (frames[i].s <= c && c < frames[i].e) busy = 1'b1;
        end
        return {16'h0, 8'(lvl), 3'b000, PBIT, ovf_m, busy, lvl == 0, lvl == DEPTH};
    endfunction

    function automatic bit all_popped(input int c);
        foreach (frames[i]) if (frames[i].s > c) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic line_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (NB == 11 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    // Called just after a rising edge; the write lands on the next edge.
    task automatic bus_wr(input logic [1:0] off, input logic [31:0] d);
        bus.MemRW    = 1'b1;
        bus.Addr_out = BASE + {28'h0, off, 2'b00};
        bus.Data_out = d;
        @(posedge clk); #1;
        bus.MemRW = 1'b0;
        case (off)
            2'd0:    push_model(d[7:0], cyc);
            2'd1:    ovf_m = 1'b0;
            2'd2:    div_m = (d[15:0] == 16'h0) ? 1 : int'(d[15:0]);
            default: ;
        endcase
    endtask

    task automatic rd_chk(input logic [1:0] off, input logic [31:0] exp, input string name);
        bus.MemRW    = 1'b0;
        bus.Addr_out = BASE + {28'h0, off, 2'b00};
        #1;
        check(name, bus.rdata, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc < last_end + 1 && n < 20000) begin step(1); n++; end
        check("idle_timeout", n < 20000, 1);
        check("irq_empty_idle", irq_empty, 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin : monitor
        frm_t f;
        int   errs;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: start bit seen at cycle %0d, none expected", cyc);
                    while (tx === 1'b0) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_start_cycle", cyc, f.s);
                    errs    = 0;
                    aborted = 1'b0;
                    for (int k = 0; k < NB * f.dv; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== line_bit(f.d, k / f.dv)) errs++;
                    end
                    if (!aborted) check("frame_bits_bad_samples", errs, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int sx;
        bus.MemRW    = 1'b0;
        bus.Addr_out = 32'h0;
        bus.Data_out = 32'h0;
        step(3);
        rst = 1'b0;
        model_reset();

        rd_chk(2'd1, status_m(cyc), "status_reset");
        check("tx_reset", tx, 1);
        check("irq_empty_reset", irq_empty, 1);
        check("sel_in_window", bus.sel, 1);
        rd_chk(2'd2, DIV_RST, "div_reset");
        rd_chk(2'd0, 32'h0, "txdata_reads_zero");
        rd_chk(2'd3, 32'h0, "reserved_reads_zero");
        bus.Addr_out = 32'h1000_0004;
        #1;
        check("sel_outside", bus.sel, 0);
        check("rdata_outside", bus.rdata, 0);

        // Single 0xA5 frame at DIV=4.
        bus_wr(2'd2, 32'd4);
        bus_wr(2'd0, 32'hA5);
        wait_idle();

        // Nine back-to-back bytes at DIV=2; irq_empty only after the final stop bit.
        bus_wr(2'd2, 32'd2);
        for (int i = 0; i < 9; i++) bus_wr(2'd0, 32'(8'h30 + i));
        while (cyc < last_end - 1) step(1);
        check("irq_before_last_stop", irq_empty, 0);
        step(1);
        check("irq_after_last_stop", irq_empty, 1);
        wait_idle();

        // Ten bytes in ten cycles at DIV=100: one popped, eight queued, one dropped.
        bus_wr(2'd2, 32'd100);
        for (int i = 0; i < 10; i++) bus_wr(2'd0, 32'(8'hC0 + i));
        rd_chk(2'd1, status_m(cyc), "status_overflow");
        bus_wr(2'd1, 32'h0);
        rd_chk(2'd1, status_m(cyc), "status_ovf_cleared");
        wait_idle();

        // DIV=0 stores 1; a DIV write mid-frame only changes the next frame.
        bus_wr(2'd2, 32'd0);
        rd_chk(2'd2, 32'd1, "div_zero_stores_one");
        bus_wr(2'd2, 32'd4);
        bus_wr(2'd0, 32'h5C);
        step(5);
        bus_wr(2'd2, 32'd3);
        bus_wr(2'd0, 32'h3A);
        rd_chk(2'd2, 32'd3, "div_mid_frame");
        wait_idle();

        // Reset while the first frame is in data bit 3 with a second byte queued.
        bus_wr(2'd2, 32'd4);
        bus_wr(2'd0, 32'h96);
        sx = last_end - NB * 4;
        bus_wr(2'd0, 32'h69);
        while (cyc < sx + 17) step(1);
        rst = 1'b1;
        model_reset();
        step(1);
        check("tx_after_mid_reset", tx, 1);
        check("irq_after_mid_reset", irq_empty, 1);
        rd_chk(2'd1, status_m(cyc), "status_after_mid_reset");
        rst = 1'b0;
        step(80);
        check("tx_quiet_after_reset", tx, 1);
        rd_chk(2'd2, DIV_RST, "div_after_mid_reset");

        // Randomized traffic: random bytes, gaps and bursts; DIV changes only when nothing waits.
        for (int i = 0; i < 30; i++) begin
            if (all_popped(cyc) && $urandom_range(0, 3) == 0)
                bus_wr(2'd2, 32'($urandom_range(0, 4)));
            bus_wr(2'd0, 32'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) != 0) step($urandom_range(1, 30));
            if (i % 10 == 9) rd_chk(2'd1, status_m(cyc), "status_random");
        end
        wait_idle();
        rd_chk(2'd1, status_m(cyc), "status_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
